// File: rtl/mem_req_adapter.sv
// mem_req_adapter: turns a valid/ready load/store request stream into single-port RAM
// accesses (1-cycle read latency) and returns one response per request.
//
// Ports
//   clka, rstb               clock; synchronous active-high reset
//   req_*_i / req_ready_o    request channel (byte address, size 00/01/10, 11 = error)
//   rsp_*_o / rsp_ready_i    response channel (load data aligned and extended, error flag)
//   ram_*_o / ram_dout_i     RAM port: enable, write, byte-lane write mask, word address, data
//
// Build option: define ALIGN_CHK_EN to turn misaligned half/word accesses into error
// responses without a RAM access. Left undefined, low address bits are simply ignored.
module mem_req_adapter #(
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_wem_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [31:0]           ram_din_o,
  input  logic [31:0]           ram_dout_i
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic        we_q;
  logic        err_q;

  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [3:0]  lane_wem;
  logic [31:0] lane_din;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q <= StIdle;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q <= req_size_i;
        off_q  <= req_addr_i[1:0];
        uns_q  <= req_unsigned_i;
        we_q   <= req_we_i;
        err_q  <= req_err;
      end
    end
  end

`ifdef ALIGN_CHK_EN
  assign misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                    ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size_i == 2'b11) || misalign;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    unique case (state_q)
      StIdle: req_ready_o = 1'b1;
      StResp: req_ready_o = rsp_ready_i;
      default: req_ready_o = 1'b0;
    endcase
    if (rstb) req_ready_o = 1'b0;

    accept = req_valid_i && req_ready_o;

    unique case (state_q)
      StIdle: if (accept) state_d = StResp;
      // An accept in StResp implies rsp_ready_i, so the new request takes the slot.
      StResp: if (rsp_ready_i && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Store lane steering: replicate narrow data across lanes, mask selects the target.
  always_comb begin
    lane_wem = 4'b1111;
    lane_din = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        lane_wem = 4'b0001 << req_addr_i[1:0];
        lane_din = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        lane_wem = req_addr_i[1] ? 4'b1100 : 4'b0011;
        lane_din = {2{req_wdata_i[15:0]}};
      end
      default: begin
        lane_wem = 4'b1111;
        lane_din = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    ram_en_o   = accept && !req_err;
    ram_we_o   = ram_en_o && req_we_i;
    ram_wem_o  = ram_we_o ? lane_wem : 4'b0000;
    ram_addr_o = ram_en_o ? req_addr_i[ADDR_WIDTH-1:2] : '0;
    ram_din_o  = ram_we_o ? lane_din : 32'h0;
  end

  // Read data comes straight from ram_dout_i; it holds while ram_en_o is low, which
  // keeps a stalled response stable without a data register.
  always_comb begin
    rsp_valid_o = (state_q == StResp) && !rstb;
    rsp_err_o   = rsp_valid_o && err_q;

    unique case (off_q)
      2'b00:   rd_byte = ram_dout_i[7:0];
      2'b01:   rd_byte = ram_dout_i[15:8];
      2'b10:   rd_byte = ram_dout_i[23:16];
      default: rd_byte = ram_dout_i[31:24];
    endcase
    rd_half = off_q[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];

    unique case (size_q)
      2'b00:   rsp_rdata_o = {{24{!uns_q && rd_byte[7]}}, rd_byte};
      2'b01:   rsp_rdata_o = {{16{!uns_q && rd_half[15]}}, rd_half};
      default: rsp_rdata_o = ram_dout_i;
    endcase
    if (!rsp_valid_o || we_q || err_q) rsp_rdata_o = 32'h0;
  end

endmodule

// File: doc/mem_req_adapter.md
MEM_REQ_ADAPTER -- requirements
Module: mem_req_adapter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 18, width of the byte address; the word address is ADDR_WIDTH-2 bits.
REQ-002 Data width SHALL be fixed at 32 bits with 4 byte lanes; lane k is bits 8k+7:8k.
REQ-003 clka  in  1  clock; all logic on posedge.
REQ-004 rstb  in  1  reset; reset rstb, synchronous, active-high; clock clka.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_WIDTH  byte address.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  32; rsp_err  out  1: response channel.
REQ-013 ram_en, ram_we  out  1; ram_wem  out  4; ram_addr  out  ADDR_WIDTH-2; ram_din  out  32; ram_dout  in  32: RAM port with 1-cycle read latency; ram_dout holds its value while ram_en is low.

Function
REQ-014 FSM states: IDLE and RESP; IDLE -> RESP on accept; RESP -> IDLE on response handshake without a new accept; RESP -> RESP on response handshake with a same-cycle accept.
REQ-015 req_ready SHALL be 1 in IDLE, equal to rsp_ready in RESP, and 0 while rstb is high.
REQ-016 RAM signals SHALL be driven combinationally in the accept cycle only: ram_en = accept and no error; ram_addr = req_addr[ADDR_WIDTH-1:2].
REQ-017 ram_en SHALL be 0 in every cycle without an accept.
REQ-018 Store byte: ram_wem = 1 << addr[1:0]; ram_din = wdata[7:0] replicated 4x.
REQ-019 Store half: ram_wem = 1100 if addr[1] else 0011; ram_din = wdata[15:0] replicated 2x.
REQ-020 Store word: ram_wem = 1111; ram_din = wdata.
REQ-021 Loads SHALL drive ram_we = 0 and ram_wem = 0000.
REQ-022 Size, addr[1:0], unsigned, we and err SHALL be registered on accept.
REQ-023 rsp_valid SHALL assert the cycle after accept for every request, and remain high with all response outputs stable until rsp_ready.
REQ-024 Load rsp_rdata = lane(s) of ram_dout selected by the registered addr[1:0] and size, shifted to bit 0, then sign- or zero-extended to 32 bits.
REQ-025 Store and error responses SHALL return rsp_rdata = 0.
REQ-026 rsp_rdata SHALL be 0 whenever rsp_valid is 0.
REQ-027 req_size 11 SHALL produce rsp_err = 1 with no RAM access.
REQ-028 Back-to-back throughput SHALL be one request per cycle while rsp_ready is held high.

Reset
REQ-029 While rstb is high, the block SHALL drive state IDLE, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 0, ram_en 0, ram_we 0, ram_wem 0.
REQ-030 Reset in RESP SHALL drop the pending response, with rsp_valid low the following cycle.

Configuration
REQ-031 With ALIGN_CHK_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL return rsp_err = 1 with no RAM access.
REQ-032 Without ALIGN_CHK_EN: half accesses SHALL ignore addr[0], word accesses SHALL ignore addr[1:0], and misalignment SHALL never raise rsp_err.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10 -> same cycle: ram_en=1, ram_we=1, wem=1111, ram_addr=4, din=0xDEADBEEF; next cycle: rsp_valid=1, err=0, rdata=0.
REQ-034 Store byte 0xA5 at 0x13 -> wem=1000, din=0xA5A5A5A5.
REQ-035 RAM word 4 = 0x80FF1234: signed byte load at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half at 0x12 -> 0xFFFF80FF.
REQ-036 Hold rsp_ready low 3 cycles after a load -> rsp_valid and rdata stable, req_ready=0, ram_en=0; then 4 back-to-back loads with rsp_ready=1 -> 4 responses in 4 consecutive cycles.
REQ-037 Word load at 0x11: with ALIGN_CHK_EN -> rsp_err=1, ram_en never high; without it -> ram_addr=4, err=0.
REQ-038 Assert rstb in the RESP state -> rsp_valid=0 and req_ready=0 in the next cycle; req_size=11 -> rsp_err=1.
